// File: rtl/histogram_readout_ctrl.sv
// Readout scheduler for the histogram chain: arbitrates histogram/frame dumps, sweeps the
// selected memory, captures fixed-latency read data into an output FIFO and tracks bin stats.
module histogram_readout_ctrl #(
    parameter int unsigned DATA_SIZE   = 4,
    parameter int unsigned DATA_NUM    = 16,
    parameter int unsigned LENGTH      = 64,
    parameter int unsigned LENGTH_SIZE = 6,
    parameter int unsigned RD_LAT      = 2,
    parameter int unsigned OFIFO_DEPTH = 4
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             his_req,
    input  logic                             frm_req,
    input  logic                             his_busy,
    output logic                             HisMemRD,
    output logic [DATA_SIZE-1:0]             HisMemRDAdd,
    input  logic [LENGTH_SIZE-1:0]           HisMemRDData,
    output logic                             FremMemRD,
    output logic [LENGTH_SIZE-3:0]           FremMemRDAdd,
    input  logic [DATA_SIZE-1:0]             FremMemRDData,
    output logic                             out_valid,
    input  logic                             out_ready,
    output logic [LENGTH_SIZE-1:0]           out_data,
    output logic                             out_last,
    output logic                             out_src,
    output logic                             busy,
    output logic                             his_done,
    output logic                             frm_done,
    output logic [LENGTH_SIZE-1:0]           max_val,
    output logic [DATA_SIZE-1:0]             max_idx,
    output logic [LENGTH_SIZE+DATA_SIZE-1:0] bin_sum
);

    localparam int unsigned AW = (DATA_SIZE > LENGTH_SIZE - 2) ? DATA_SIZE : LENGTH_SIZE - 2;
    localparam int unsigned PW = (OFIFO_DEPTH > 1) ? $clog2(OFIFO_DEPTH) : 1;
    localparam int unsigned CW = PW + 1;
    localparam int unsigned SW = LENGTH_SIZE + DATA_SIZE;
    localparam logic [AW-1:0] HIS_END = AW'(DATA_NUM - 1);
    localparam logic [AW-1:0] FRM_END = AW'(LENGTH / 4 - 1);

    typedef enum logic [2:0] {S_IDLE, S_HIS_RD, S_FRM_RD, S_DRAIN, S_DONE} state_t;

    state_t                 state, state_nxt;
    logic                   last_grant, last_grant_nxt;   // 1 = frame was granted last
    logic                   dump_src;
    logic [AW-1:0]          addr, addr_nxt;
    logic                   his_grant, frm_grant, his_rd, frm_rd, strobe_last, room;
    logic [RD_LAT-1:0]      pipe_v, pipe_last, pipe_src;
    logic [LENGTH_SIZE-1:0] fifo_data [OFIFO_DEPTH];
    logic                   fifo_last [OFIFO_DEPTH];
    logic                   fifo_src  [OFIFO_DEPTH];
    logic [PW-1:0]          wr_ptr, rd_ptr;
    logic [CW-1:0]          fifo_count;
    logic                   push, pop;
    logic [LENGTH_SIZE-1:0] cap_data;
    logic [DATA_SIZE-1:0]   cap_idx;

    // Issue only while every outstanding read is guaranteed a FIFO slot.
    assign room = (32'(fifo_count) + 32'($countones(pipe_v))) < 32'(OFIFO_DEPTH);

    assign HisMemRD     = his_rd;
    assign FremMemRD    = frm_rd;
    assign HisMemRDAdd  = addr[DATA_SIZE-1:0];
    assign FremMemRDAdd = addr[LENGTH_SIZE-3:0];

    assign push      = pipe_v[RD_LAT-1];
    assign cap_data  = pipe_src[RD_LAT-1] ? LENGTH_SIZE'(FremMemRDData) : HisMemRDData;
    assign out_valid = (fifo_count != '0);
    assign out_data  = fifo_data[rd_ptr];
    assign out_last  = fifo_last[rd_ptr];
    assign out_src   = fifo_src[rd_ptr];
    assign pop       = out_valid && out_ready;

    always_comb begin
        state_nxt      = state;
        addr_nxt       = addr;
        last_grant_nxt = last_grant;
        his_grant      = 1'b0;
        frm_grant      = 1'b0;
        his_rd         = 1'b0;
        frm_rd         = 1'b0;
        strobe_last    = 1'b0;
        case (state)
            S_IDLE: begin
                if (his_req && (!frm_req || last_grant)) begin
                    his_grant      = 1'b1;
                    last_grant_nxt = 1'b0;
                    addr_nxt       = '0;
                    state_nxt      = S_HIS_RD;
                end else if (frm_req) begin
                    frm_grant      = 1'b1;
                    last_grant_nxt = 1'b1;
                    addr_nxt       = '0;
                    state_nxt      = S_FRM_RD;
                end
            end
            S_HIS_RD: begin
                if (room && !his_busy) begin
                    his_rd = 1'b1;
                    if (addr == HIS_END) begin
                        strobe_last = 1'b1;
                        state_nxt   = S_DRAIN;
                    end else begin
                        addr_nxt = addr + AW'(1);
                    end
                end
            end
            S_FRM_RD: begin
                if (room) begin
                    frm_rd = 1'b1;
                    if (addr == FRM_END) begin
                        strobe_last = 1'b1;
                        state_nxt   = S_DRAIN;
                    end else begin
                        addr_nxt = addr + AW'(1);
                    end
                end
            end
            S_DRAIN:  if (pop && out_last) state_nxt = S_DONE;
            S_DONE:   state_nxt = S_IDLE;
            default:  state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= S_IDLE;
            last_grant <= 1'b1;
            dump_src   <= 1'b0;
            addr       <= '0;
            busy       <= 1'b0;
            his_done   <= 1'b0;
            frm_done   <= 1'b0;
        end else begin
            state      <= state_nxt;
            last_grant <= last_grant_nxt;
            addr       <= addr_nxt;
            if (his_grant) dump_src <= 1'b0;
            if (frm_grant) dump_src <= 1'b1;
            busy       <= (state_nxt != S_IDLE);
            his_done   <= (state_nxt == S_DONE) && !dump_src;
            frm_done   <= (state_nxt == S_DONE) && dump_src;
        end
    end

    // Tag pipe aligns each strobe with the cycle its read data is valid.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pipe_v    <= '0;
            pipe_last <= '0;
            pipe_src  <= '0;
        end else begin
            pipe_v[0]    <= his_rd || frm_rd;
            pipe_last[0] <= strobe_last;
            pipe_src[0]  <= frm_rd;
            for (int i = 1; i < int'(RD_LAT); i++) begin
                pipe_v[i]    <= pipe_v[i-1];
                pipe_last[i] <= pipe_last[i-1];
                pipe_src[i]  <= pipe_src[i-1];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
            for (int i = 0; i < int'(OFIFO_DEPTH); i++) begin
                fifo_data[i] <= '0;
                fifo_last[i] <= 1'b0;
                fifo_src[i]  <= 1'b0;
            end
        end else begin
            if (push) begin
                fifo_data[wr_ptr] <= cap_data;
                fifo_last[wr_ptr] <= pipe_last[RD_LAT-1];
                fifo_src[wr_ptr]  <= pipe_src[RD_LAT-1];
                wr_ptr            <= wr_ptr + PW'(1);
            end
            if (pop) rd_ptr <= rd_ptr + PW'(1);
            fifo_count <= fifo_count + CW'(push) - CW'(pop);
        end
    end

    // Ties keep the earliest index because only a strictly larger bin replaces the max.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            max_val <= '0;
            max_idx <= '0;
            bin_sum <= '0;
            cap_idx <= '0;
        end else if (his_grant) begin
            max_val <= '0;
            max_idx <= '0;
            bin_sum <= '0;
            cap_idx <= '0;
        end else if (push && !pipe_src[RD_LAT-1]) begin
            if (HisMemRDData > max_val) begin
                max_val <= HisMemRDData;
                max_idx <= cap_idx;
            end
            bin_sum <= bin_sum + SW'(HisMemRDData);
            cap_idx <= cap_idx + DATA_SIZE'(1);
        end
    end

endmodule

// File: tb/tb_histogram_readout_ctrl.sv
// Self-checking bench for histogram_readout_ctrl: memory models with fixed read latency,
// a list-based beat/statistics reference and per-scenario tasks.
module tb_histogram_readout_ctrl;

    localparam int DS = 4;
    localparam int DN = 16;
    localparam int LEN = 64;
    localparam int LS = 6;
    localparam int RL = 2;
    localparam int OD = 4;
    localparam int NF = LEN / 4;

    logic clk = 1'b0;
    logic rst;
    logic his_req, frm_req, his_busy, out_ready;
    logic HisMemRD, FremMemRD, out_valid, out_last, out_src, busy, his_done, frm_done;
    logic [DS-1:0] HisMemRDAdd, max_idx;
    logic [LS-3:0] FremMemRDAdd;
    logic [LS-1:0] HisMemRDData, out_data, max_val;
    logic [DS-1:0] FremMemRDData;
    logic [LS+DS-1:0] bin_sum;

    logic [LS-1:0] his_mem [DN];
    logic [DS-1:0] frm_mem [NF];
    logic [RL-1:0] hp_v = '0;
    logic [RL-1:0] fp_v = '0;
    logic [DS-1:0] hp_a [RL];
    logic [LS-3:0] fp_a [RL];

    int n_checks = 0;
    int n_fail = 0;
    logic model_last;
    logic [LS-1:0] exp_max;
    logic [DS-1:0] exp_idx;
    int exp_sum;

    always #5 clk = ~clk;

    histogram_readout_ctrl dut (
        .clk(clk), .rst(rst), .his_req(his_req), .frm_req(frm_req), .his_busy(his_busy),
        .HisMemRD(HisMemRD), .HisMemRDAdd(HisMemRDAdd), .HisMemRDData(HisMemRDData),
        .FremMemRD(FremMemRD), .FremMemRDAdd(FremMemRDAdd), .FremMemRDData(FremMemRDData),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_last(out_last),
        .out_src(out_src), .busy(busy), .his_done(his_done), .frm_done(frm_done),
        .max_val(max_val), .max_idx(max_idx), .bin_sum(bin_sum)
    );

    // Memories return data RD_LAT clocks after the strobe, garbage otherwise.
    always @(posedge clk) begin
        hp_v[0] <= HisMemRD;
        hp_a[0] <= HisMemRDAdd;
        fp_v[0] <= FremMemRD;
        fp_a[0] <= FremMemRDAdd;
        for (int i = 1; i < RL; i++) begin
            hp_v[i] <= hp_v[i-1];
            hp_a[i] <= hp_a[i-1];
            fp_v[i] <= fp_v[i-1];
            fp_a[i] <= fp_a[i-1];
        end
    end
    assign HisMemRDData  = hp_v[RL-1] ? his_mem[hp_a[RL-1]] : 6'h3F;
    assign FremMemRDData = fp_v[RL-1] ? frm_mem[fp_a[RL-1]] : 4'hF;

    task automatic do_reset();
        rst = 1'b1; his_req = 1'b0; frm_req = 1'b0; his_busy = 1'b0; out_ready = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        model_last = 1'b1;
        exp_max = '0; exp_idx = '0; exp_sum = 0;
    endtask

    // One complete dump with the current requests; checks beats, issue order, bounds and stats.
    task automatic run_dump(input int ready_mode, input int busy_addr);
        logic exp_src;
        logic [LS-1:0] exp_beats [$];
        int n, beat, issued, popped, iss_err, ovl, busy_err, over_err, hd, fd, cyc, busy_left, a;
        bit fired, done, prev_stall;
        logic [LS-1:0] pd;
        logic pl, ps;
        exp_src = (his_req && (!frm_req || model_last)) ? 1'b0 : 1'b1;
        model_last = exp_src;
        exp_beats = {};
        if (!exp_src) begin
            exp_max = '0; exp_idx = '0; exp_sum = 0;
            for (int i = 0; i < DN; i++) begin
                exp_beats.push_back(his_mem[i]);
                exp_sum += int'(his_mem[i]);
                if (his_mem[i] > exp_max) begin exp_max = his_mem[i]; exp_idx = DS'(i); end
            end
        end else begin
            for (int i = 0; i < NF; i++) exp_beats.push_back(LS'(frm_mem[i]));
        end
        n = exp_beats.size();
        beat = 0; issued = 0; popped = 0; iss_err = 0; ovl = 0; busy_err = 0; over_err = 0;
        hd = 0; fd = 0; cyc = 0; busy_left = 0; fired = 0; done = 0; prev_stall = 0;
        pd = '0; pl = 1'b0; ps = 1'b0;
        while (!done && cyc < 1000) begin
            @(negedge clk);
            cyc++;
            case (ready_mode)
                0:       out_ready = 1'b1;
                1:       out_ready = cyc[0];
                default: out_ready = 1'($urandom_range(0, 1));
            endcase
            if (!fired && busy_addr >= 0 && !exp_src && busy && int'(HisMemRDAdd) == busy_addr
                && issued == busy_addr) begin
                fired = 1; busy_left = 5;
            end
            his_busy = (busy_left > 0);
            #1;
            if (his_busy && HisMemRD) busy_err++;
            if (busy_left > 0) busy_left--;
            if (HisMemRD && FremMemRD) ovl++;
            if (HisMemRD || FremMemRD) begin
                a = HisMemRD ? int'(HisMemRDAdd) : int'(FremMemRDAdd);
                if (HisMemRD !== !exp_src || a != issued) iss_err++;
                issued++;
            end
            if (prev_stall) begin
                n_checks++;
                if (out_valid !== 1'b1 || out_data !== pd || out_last !== pl || out_src !== ps) begin
                    n_fail++;
                    $display("FAIL stall_hold: valid=%0b data=%0h last=%0b src=%0b, want 1/%0h/%0b/%0b",
                             out_valid, out_data, out_last, out_src, pd, pl, ps);
                end
            end
            prev_stall = out_valid && !out_ready;
            pd = out_data; pl = out_last; ps = out_src;
            if (out_valid && out_ready) begin
                n_checks++;
                if (beat >= n || out_data !== exp_beats[beat] || out_last !== 1'(beat == n - 1)
                    || out_src !== exp_src) begin
                    n_fail++;
                    $display("FAIL beat%0d: data=%0h last=%0b src=%0b, want %0h/%0b/%0b", beat,
                             out_data, out_last, out_src, (beat < n) ? exp_beats[beat] : '0,
                             1'(beat == n - 1), exp_src);
                end
                beat++; popped++;
            end
            if (issued - popped > OD) over_err++;
            if (his_done) begin hd++; his_req = 1'b0; done = 1; end
            if (frm_done) begin fd++; frm_req = 1'b0; done = 1; end
        end
        his_busy = 1'b0;
        @(negedge clk); #1;
        n_checks++;
        if (!done || beat != n || issued != n) begin
            n_fail++;
            $display("FAIL dump_complete: done=%0b beats=%0d issued=%0d, want 1/%0d/%0d", done, beat, issued, n, n);
        end
        n_checks++;
        if (hd != int'(!exp_src) || fd != int'(exp_src)) begin
            n_fail++;
            $display("FAIL done_pulses: his=%0d frm=%0d, want %0d/%0d", hd, fd, int'(!exp_src), int'(exp_src));
        end
        n_checks++;
        if (busy !== 1'b0 || his_done !== 1'b0 || frm_done !== 1'b0) begin
            n_fail++;
            $display("FAIL after_done: busy=%0b his_done=%0b frm_done=%0b, want 0/0/0", busy, his_done, frm_done);
        end
        n_checks++;
        if (iss_err != 0 || ovl != 0 || busy_err != 0 || over_err != 0) begin
            n_fail++;
            $display("FAIL issue_rules: order=%0d overlap=%0d busy=%0d overfill=%0d, want 0/0/0/0",
                     iss_err, ovl, busy_err, over_err);
        end
        if (busy_addr >= 0) begin
            n_checks++;
            if (!fired) begin
                n_fail++;
                $display("FAIL busy_window: triggered=%0b, want 1", fired);
            end
        end
        n_checks++;
        if (max_val !== exp_max || max_idx !== exp_idx || int'(bin_sum) != exp_sum) begin
            n_fail++;
            $display("FAIL stats: max=%0d idx=%0d sum=%0d, want %0d/%0d/%0d",
                     max_val, max_idx, bin_sum, exp_max, exp_idx, exp_sum);
        end
    endtask

    task automatic test_reset();
        do_reset();
        #1;
        n_checks++;
        if (out_valid !== 1'b0 || busy !== 1'b0 || his_done !== 1'b0 || frm_done !== 1'b0
            || HisMemRD !== 1'b0 || FremMemRD !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_ctrl: valid=%0b busy=%0b hd=%0b fd=%0b hrd=%0b frd=%0b, want all 0",
                     out_valid, busy, his_done, frm_done, HisMemRD, FremMemRD);
        end
        n_checks++;
        if (max_val !== '0 || max_idx !== '0 || bin_sum !== '0) begin
            n_fail++;
            $display("FAIL reset_stats: max=%0d idx=%0d sum=%0d, want 0/0/0", max_val, max_idx, bin_sum);
        end
    endtask

    task automatic test_his_dump();
        for (int i = 0; i < DN; i++) his_mem[i] = '0;
        his_mem[3] = 6'd5; his_mem[9] = 6'd11;
        his_req = 1'b1;
        run_dump(0, -1);
        n_checks++;
        if (max_val !== 6'd11 || max_idx !== 4'd9 || bin_sum !== 10'd16) begin
            n_fail++;
            $display("FAIL his_stats_fixed: max=%0d idx=%0d sum=%0d, want 11/9/16", max_val, max_idx, bin_sum);
        end
    endtask

    task automatic test_frame_backpressure();
        for (int i = 0; i < NF; i++) frm_mem[i] = DS'(i);
        frm_req = 1'b1;
        run_dump(1, -1);
    endtask

    task automatic test_arbitration();
        do_reset();
        his_req = 1'b1; frm_req = 1'b1;
        run_dump(0, -1);
        n_checks++;
        if (frm_req !== 1'b1 || model_last !== 1'b0) begin
            n_fail++;
            $display("FAIL arb_first: frm_req=%0b granted_frame=%0b, want 1/0", frm_req, model_last);
        end
        run_dump(2, -1);
        his_req = 1'b1;
        run_dump(0, -1);
        his_req = 1'b1; frm_req = 1'b1;
        run_dump(0, -1);
        n_checks++;
        if (his_req !== 1'b1 || model_last !== 1'b1) begin
            n_fail++;
            $display("FAIL arb_second: his_req=%0b granted_frame=%0b, want 1/1", his_req, model_last);
        end
        run_dump(0, -1);
    endtask

    task automatic test_his_busy();
        for (int i = 0; i < DN; i++) his_mem[i] = LS'(i);
        his_req = 1'b1;
        run_dump(0, 6);
    endtask

    task automatic test_tie();
        for (int i = 0; i < DN; i++) his_mem[i] = '0;
        his_mem[2] = 6'd9; his_mem[7] = 6'd9;
        his_req = 1'b1;
        run_dump(2, -1);
        n_checks++;
        if (max_val !== 6'd9 || max_idx !== 4'd2 || bin_sum !== 10'd18) begin
            n_fail++;
            $display("FAIL tie_stats: max=%0d idx=%0d sum=%0d, want 9/2/18", max_val, max_idx, bin_sum);
        end
    endtask

    task automatic test_random();
        int r;
        for (int k = 0; k < 8; k++) begin
            for (int i = 0; i < DN; i++) his_mem[i] = LS'($urandom_range(0, 62));
            for (int i = 0; i < NF; i++) frm_mem[i] = DS'($urandom);
            r = int'($urandom_range(0, 2));
            his_req = (r != 1);
            frm_req = (r != 0);
            run_dump(int'($urandom_range(0, 2)), -1);
            if (his_req || frm_req) run_dump(int'($urandom_range(0, 2)), -1);
        end
    endtask

    task automatic test_reset_mid();
        int beats, cyc, hd;
        for (int i = 0; i < DN; i++) his_mem[i] = LS'($urandom_range(1, 62));
        his_req = 1'b1; out_ready = 1'b1;
        beats = 0; cyc = 0; hd = 0;
        while (beats < 8 && cyc < 200) begin
            @(negedge clk); #1;
            cyc++;
            if (out_valid && out_ready) beats++;
        end
        @(negedge clk);
        rst = 1'b1;
        #1;
        n_checks++;
        if (beats != 8 || out_valid !== 1'b0 || busy !== 1'b0 || HisMemRD !== 1'b0 || his_done !== 1'b0) begin
            n_fail++;
            $display("FAIL mid_reset: beats=%0d valid=%0b busy=%0b hrd=%0b hd=%0b, want 8/0/0/0/0",
                     beats, out_valid, busy, HisMemRD, his_done);
        end
        n_checks++;
        if (max_val !== '0 || bin_sum !== '0) begin
            n_fail++;
            $display("FAIL mid_reset_stats: max=%0d sum=%0d, want 0/0", max_val, bin_sum);
        end
        his_req = 1'b0;
        repeat (3) begin
            @(negedge clk); #1;
            if (his_done || frm_done) hd++;
        end
        rst = 1'b0;
        model_last = 1'b1;
        exp_max = '0; exp_idx = '0; exp_sum = 0;
        repeat (2) begin
            @(negedge clk); #1;
            if (his_done || frm_done || busy) hd++;
        end
        n_checks++;
        if (hd != 0) begin
            n_fail++;
            $display("FAIL mid_reset_quiet: spurious=%0d, want 0", hd);
        end
        his_req = 1'b1;
        run_dump(0, -1);
    endtask

    initial begin
        test_reset();
        test_his_dump();
        test_frame_backpressure();
        test_arbitration();
        test_his_busy();
        test_tie();
        test_random();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
